period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures a slow square wave, such as the output of the team's clock divider or an external sensor/beacon line, against the fast system clock.
- Reports the high time, low time and full period in clk cycles.
- Flags a lock once measurements are stable and a stale condition when the signal stops toggling.
- Used by the alarm controller to check that divided timebases and sensor heartbeats are alive and at the expected rate.

Parameters:
- CNT_W, 28: width of the cycle counter and of the half-period outputs.
- TIMEOUT, 50_000_000: clk cycles without an input edge before the signal is declared stale. Must be ≤ 2^CNT_W − 1.
- LOCK_COUNT, 4: number of consecutive in-tolerance half-period measurements required to assert locked (≥ 2).
- TOL, 2: maximum absolute difference, in clk cycles, between a half-period and the previous half-period of the same phase for it to count as in-tolerance.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- sig_in, input, 1: measured signal, asynchronous to clk.
- half_period, output, CNT_W: last completed half-period length in clk cycles.
- half_level, output, 1: level of sig_in during the reported half-period (1 = high time).
- half_valid, output, 1: one-cycle strobe; half_period and half_level are updated this cycle.
- period, output, CNT_W+1: high time + low time of the last full cycle.
- period_valid, output, 1: one-cycle strobe; period updated this cycle.
- locked, output, 1: level; measurements are stable.
- stale, output, 1: level; no edge for TIMEOUT cycles.

Behaviour:
- Input path:
  - Two-flop synchroniser on sig_in, then a previous-value register.
  - An edge is detected when sync2 != prev. Both rising and falling edges count.
- Counter cnt:
  - Cleared to 0 on the cycle an edge is detected.
  - Otherwise increments, saturating at TIMEOUT.
  - The captured half-period is cnt + 1, i.e. clk cycles between consecutive detected edges. A divider toggling every C+1 cycles measures C+1.
- FSM states:
  - IDLE (after reset): first edge → FIRST; nothing reported.
  - FIRST: next edge → MEASURE and reports the first half-period (half_valid=1). No period yet.
  - MEASURE: each edge reports a half-period. half_level = level before the edge.
  - Timeout, from FIRST or MEASURE: cnt reaching TIMEOUT−1 with no edge → STALE.
  - STALE: edge → FIRST (the partial interval is not reported); stale clears on that edge.
- Period: period_valid pulses on the same cycle as half_valid, from the second reported half-period onward after entering MEASURE. period = current half + previous opposite-level half, computed at CNT_W+1 bits with no overflow.
- Latency: half_valid asserts on the 3rd rising clk edge after the edge at which the sig_in change is first sampled. Constant latency, so measured values are exact.
- Lock:
  - A tolerance counter increments on each half-period with |new − previous same-level half| ≤ TOL.
  - The counter resets to 0 on an out-of-tolerance measurement.
  - locked=1 when the counter reaches LOCK_COUNT; the counter saturates there.
  - locked clears on the same cycle as an out-of-tolerance half_valid, or on entering STALE.
  - The first measurement of each level after FIRST has no reference and counts as neither in nor out; the counter is held.
- Stale:
  - On entering STALE: stale=1, locked=0, tolerance history cleared.
  - half_period and period retain their last values.
- Simultaneous events: an edge on the same cycle cnt hits TIMEOUT−1 is an edge (no stale).
- Reset values: half_period=0, half_level=0, half_valid=0, period=0, period_valid=0, locked=0, stale=0, cnt=0, state=IDLE, synchroniser flops=0.
- Reset mid-measurement discards everything; the first edge afterwards only arms FIRST.
- sig_in pulses shorter than 2 clk cycles may be missed. This is not an error; the result is a longer measured interval.

Test Plan:
- Reset, then sig_in square wave toggling every 4 clk cycles (divider ciclos=3) → first half_valid on the 2nd detected edge, with half_period=4; period_valid from the 3rd detected edge, period=8.
- Asymmetric wave, high 10 / low 6 cycles:
  - half_period alternates 10 (half_level=1) and 6 (half_level=0).
  - period=16.
  - locked rises on the cycle of the 6th reported half-period (LOCK_COUNT=4) and stays 1.
- Locked stream at 10/10, then one high phase of 13 cycles (TOL=2) → locked drops on that half_valid cycle; re-asserts after 4 further in-tolerance halves.
- TIMEOUT=100, sig_in held static after lock:
  - stale=1 and locked=0 exactly 100 cycles after the last detected edge.
  - Outputs are retained.
  - Resuming toggling clears stale on the first edge, and the next half_valid reports the correct value.
- Edge arriving exactly when cnt=TIMEOUT−1 → no stale, half_period=TIMEOUT reported.
- Assert rst for 1 cycle mid-high-phase → all outputs 0 next cycle; the first subsequent edge produces no half_valid.

Source files
------------

// File: rtl/period_meter.sv
// period_meter: measures high time, low time and full period of a slow signal in clk cycles, with lock and stale flags
module period_meter #(
   parameter int CNT_W      = 28,
   parameter int TIMEOUT    = 50_000_000,
   parameter int LOCK_COUNT = 4,
   parameter int TOL        = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] half_period,
   output logic             half_level,
   output logic             half_valid,
   output logic [CNT_W:0]   period,
   output logic             period_valid,
   output logic             locked,
   output logic             stale
);
   localparam int LW = $clog2(LOCK_COUNT + 1);
   typedef enum logic [1:0] {IDLE, FIRST, MEASURE, STALE} state_t;
   state_t state, state_n;
   logic sync1, sync2, prev, edge_det;
   logic [2:0] warm;
   logic [CNT_W-1:0] cnt;
   logic ev_edge, ev_lvl, ev_to;
   logic [CNT_W-1:0] ev_len, ref_hi, ref_lo, ref_hi_n, ref_lo_n, ref_sel, diff;
   logic has_hi, has_lo, has_hi_n, has_lo_n, has_sel, in_tol, active;
   logic [LW-1:0] tol_cnt, tol_n;
   logic [CNT_W-1:0] half_period_n;
   logic [CNT_W:0] period_n;
   logic half_level_n, half_valid_n, period_valid_n, locked_n, stale_n;

   // warm masks the spurious edge seen while the synchroniser fills after reset
   assign edge_det = warm[2] & (sync2 ^ prev);
   assign active   = (state == FIRST) || (state == MEASURE);
   assign ref_sel  = ev_lvl ? ref_hi : ref_lo;
   assign has_sel  = ev_lvl ? has_hi : has_lo;
   assign diff     = (ev_len >= ref_sel) ? ev_len - ref_sel : ref_sel - ev_len;
   assign in_tol   = diff <= CNT_W'(TOL);

   // synchroniser, edge detection, interval counter and one-stage event register
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         prev    <= 1'b0;
         warm    <= '0;
         cnt     <= '0;
         ev_edge <= 1'b0;
         ev_lvl  <= 1'b0;
         ev_len  <= '0;
         ev_to   <= 1'b0;
      end else begin
         sync1   <= sig_in;
         sync2   <= sync1;
         prev    <= sync2;
         warm    <= {warm[1:0], 1'b1};
         cnt     <= edge_det ? '0 : (cnt < CNT_W'(TIMEOUT)) ? cnt + 1'b1 : cnt;
         ev_edge <= edge_det;
         ev_lvl  <= prev;
         ev_len  <= cnt + 1'b1;
         ev_to   <= !edge_det && (cnt == CNT_W'(TIMEOUT - 1));
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end

   // reported values and tolerance history
   always_ff @(posedge clk) begin
      if (rst) begin
         half_period  <= '0;
         half_level   <= 1'b0;
         half_valid   <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         stale        <= 1'b0;
         tol_cnt      <= '0;
         ref_hi       <= '0;
         ref_lo       <= '0;
         has_hi       <= 1'b0;
         has_lo       <= 1'b0;
      end else begin
         half_period  <= half_period_n;
         half_level   <= half_level_n;
         half_valid   <= half_valid_n;
         period       <= period_n;
         period_valid <= period_valid_n;
         locked       <= locked_n;
         stale        <= stale_n;
         tol_cnt      <= tol_n;
         ref_hi       <= ref_hi_n;
         ref_lo       <= ref_lo_n;
         has_hi       <= has_hi_n;
         has_lo       <= has_lo_n;
      end
   end

   // next state, half/period reporting and lock tracking; an edge wins over a coincident timeout
   always_comb begin
      state_n        = state;
      half_period_n  = half_period;
      half_level_n   = half_level;
      half_valid_n   = 1'b0;
      period_n       = period;
      period_valid_n = 1'b0;
      locked_n       = locked;
      stale_n        = stale;
      tol_n          = tol_cnt;
      ref_hi_n       = ref_hi;
      ref_lo_n       = ref_lo;
      has_hi_n       = has_hi;
      has_lo_n       = has_lo;
      if (ev_edge && !active) begin
         state_n  = FIRST;
         stale_n  = 1'b0;
         locked_n = 1'b0;
         tol_n    = '0;
         has_hi_n = 1'b0;
         has_lo_n = 1'b0;
      end else if (ev_edge) begin
         state_n       = MEASURE;
         half_valid_n  = 1'b1;
         half_period_n = ev_len;
         half_level_n  = ev_lvl;
         if (state == MEASURE) begin
            period_valid_n = 1'b1;
            period_n       = {1'b0, ev_len} + {1'b0, half_period};
         end
         if (ev_lvl) begin
            ref_hi_n = ev_len;
            has_hi_n = 1'b1;
         end else begin
            ref_lo_n = ev_len;
            has_lo_n = 1'b1;
         end
         if (has_sel) begin
            tol_n    = !in_tol ? '0 : (tol_cnt == LW'(LOCK_COUNT)) ? tol_cnt : tol_cnt + 1'b1;
            locked_n = tol_n == LW'(LOCK_COUNT);
         end
      end else if (ev_to && active) begin
         state_n  = STALE;
         stale_n  = 1'b1;
         locked_n = 1'b0;
         tol_n    = '0;
         has_hi_n = 1'b0;
         has_lo_n = 1'b0;
      end
   end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed checks of period_meter reporting, latency, lock, stale and reset behaviour
module tb_period_meter;
   localparam int W = 28;
   logic clk = 1'b0, rst = 1'b1, sig_in = 1'b0;
   logic [W-1:0] half_period;
   logic [W:0] period;
   logic half_level, half_valid, period_valid, locked, stale;
   typedef struct {int hp; logic lv; logic pv; int p; logic lk; int cyc;} ev_t;
   ev_t q[$];
   int cyc = 0, errors = 0, checks = 0, st_rise = 0, last_cyc = 0, t0 = 0;
   logic st_prev = 1'b0;
   int hp3[13] = '{10, 10, 10, 10, 10, 10, 13, 10, 10, 10, 10, 10, 10};
   int p3[13]  = '{0, 20, 20, 20, 20, 20, 23, 23, 20, 20, 20, 20, 20};
   int lk3[13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};

   period_meter #(.CNT_W(W), .TIMEOUT(100), .LOCK_COUNT(4), .TOL(2)) dut (
      .clk(clk), .rst(rst), .sig_in(sig_in), .half_period(half_period), .half_level(half_level),
      .half_valid(half_valid), .period(period), .period_valid(period_valid), .locked(locked), .stale(stale)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic run(input logic lv, input int n);
      sig_in = lv;
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
         if (half_valid) q.push_back('{int'(half_period), half_level, period_valid, int'(period), locked, cyc});
         if (stale && !st_prev) st_rise = cyc;
         st_prev = stale;
      end
   endtask

   task automatic exp_half(input string tag, input int hp, input logic lv, input logic pv, input int p, input logic lk);
      ev_t e;
      chk({tag, "_present"}, 64'(q.size() != 0), 64'd1);
      if (q.size() == 0) return;
      e = q.pop_front();
      last_cyc = e.cyc;
      chk({tag, "_half_period"}, 64'(e.hp), 64'(hp));
      chk({tag, "_half_level"}, 64'(e.lv), 64'(lv));
      chk({tag, "_period_valid"}, 64'(e.pv), 64'(pv));
      if (pv) chk({tag, "_period"}, 64'(e.p), 64'(p));
      chk({tag, "_locked"}, 64'(e.lk), 64'(lk));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run(1'b0, 2);
      rst = 1'b0;
      q.delete();
      run(1'b0, 5);
   endtask

   initial begin
      run(1'b0, 3);
      chk("rst_half_period", 64'(half_period), 0);
      chk("rst_half_level", 64'(half_level), 0);
      chk("rst_half_valid", 64'(half_valid), 0);
      chk("rst_period", 64'(period), 0);
      chk("rst_period_valid", 64'(period_valid), 0);
      chk("rst_locked", 64'(locked), 0);
      chk("rst_stale", 64'(stale), 0);
      rst = 1'b0;
      run(1'b0, 5);
      run(1'b1, 4);
      chk("arm_no_report", 64'(q.size()), 0);
      t0 = cyc;
      run(1'b0, 4);
      run(1'b1, 4);
      run(1'b0, 4);
      run(1'b1, 4);
      chk("latency", 64'(q.size() > 0 ? q[0].cyc : 0), 64'(t0 + 4));
      exp_half("sq1", 4, 1'b1, 1'b0, 0, 1'b0);
      exp_half("sq2", 4, 1'b0, 1'b1, 8, 1'b0);
      exp_half("sq3", 4, 1'b1, 1'b1, 8, 1'b0);
      exp_half("sq4", 4, 1'b0, 1'b1, 8, 1'b0);

      do_reset();
      run(1'b1, 10);
      for (int i = 0; i < 4; i++) begin
         run(1'b0, 6);
         run(1'b1, 10);
      end
      for (int i = 0; i < 8; i++)
         exp_half("asym", (i % 2 == 0) ? 10 : 6, logic'(i % 2 == 0), logic'(i > 0), 16, logic'(i >= 5));

      do_reset();
      run(1'b1, 10);
      for (int i = 0; i < 3; i++) begin
         run(1'b0, 10);
         run(1'b1, 10);
      end
      run(1'b1, 3);
      for (int i = 0; i < 3; i++) begin
         run(1'b0, 10);
         run(1'b1, 10);
      end
      run(1'b0, 10);
      for (int i = 0; i < 13; i++)
         exp_half("tol", hp3[i], logic'(i % 2 == 0), logic'(i > 0), p3[i], logic'(lk3[i]));

      st_rise = 0;
      run(1'b0, 150);
      chk("stale_time", 64'(st_rise), 64'(last_cyc + 100));
      chk("stale_level", 64'(stale), 1);
      chk("stale_unlock", 64'(locked), 0);
      chk("stale_keep_half", 64'(half_period), 10);
      chk("stale_keep_period", 64'(period), 20);
      chk("stale_no_report", 64'(q.size()), 0);
      run(1'b1, 10);
      chk("resume_stale_clear", 64'(stale), 0);
      chk("resume_no_report", 64'(q.size()), 0);
      run(1'b0, 10);
      exp_half("resume", 10, 1'b1, 1'b0, 0, 1'b0);

      st_rise = 0;
      run(1'b0, 90);
      run(1'b1, 10);
      exp_half("tmo_edge", 100, 1'b0, 1'b1, 110, 1'b0);
      chk("tmo_edge_no_stale", 64'(st_rise), 0);
      chk("tmo_edge_stale", 64'(stale), 0);

      run(1'b1, 5);
      rst = 1'b1;
      run(1'b1, 1);
      rst = 1'b0;
      chk("mid_rst_half_period", 64'(half_period), 0);
      chk("mid_rst_period", 64'(period), 0);
      chk("mid_rst_half_valid", 64'(half_valid), 0);
      chk("mid_rst_locked", 64'(locked), 0);
      chk("mid_rst_stale", 64'(stale), 0);
      q.delete();
      run(1'b1, 6);
      run(1'b0, 10);
      chk("mid_rst_arm_only", 64'(q.size()), 0);
      run(1'b1, 10);
      exp_half("post_rst", 10, 1'b0, 1'b0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
